// File: rtl/uart_rx_fsm_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : uart_rx_fsm_if
// Brief  : Serial line, checker results and strobes of the UART RX frame controller
// Rev    : 1.0
// ----------------------------------------------------------------------------
interface uart_rx_fsm_if #(
    parameter int PRESCALE_W = 6
);
    logic                  RX_IN;
    logic [PRESCALE_W-1:0] Prescale;
    logic                  PAR_EN;
    logic                  strt_glitch;
    logic                  par_err;
    logic                  stp_err;
    logic [PRESCALE_W-1:0] edge_cnt;
    logic [3:0]            bit_cnt;
    logic                  data_samp_en;
    logic                  deser_en;
    logic                  strt_chk_en;
    logic                  par_chk_en;
    logic                  stp_chk_en;
    logic                  done_chk;
    logic                  data_valid;
    logic                  frame_err;

    modport slave (
        input  RX_IN, Prescale, PAR_EN, strt_glitch, par_err, stp_err,
        output edge_cnt, bit_cnt, data_samp_en, deser_en, strt_chk_en,
               par_chk_en, stp_chk_en, done_chk, data_valid, frame_err
    );

    modport master (
        output RX_IN, Prescale, PAR_EN, strt_glitch, par_err, stp_err,
        input  edge_cnt, bit_cnt, data_samp_en, deser_en, strt_chk_en,
               par_chk_en, stp_chk_en, done_chk, data_valid, frame_err
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_fsm.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : uart_rx_fsm
// Brief  : UART RX frame sequencer: start, data, optional parity, stop, done
// Rev    : 1.0
// ----------------------------------------------------------------------------
module uart_rx_fsm #(
    parameter int PRESCALE_W = 6,
    parameter int DATA_W     = 8
) (
    input wire           clk,
    input wire           rst,
    uart_rx_fsm_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [3:0]            c_LAST_DATA_BIT = 4'(DATA_W);
    localparam logic [PRESCALE_W-1:0] c_ONE           = PRESCALE_W'(1);
    localparam logic [PRESCALE_W-1:0] c_TWO           = PRESCALE_W'(2);

    state_t                r_state;
    state_t                w_next;
    logic [PRESCALE_W-1:0] r_edge_cnt;
    logic [PRESCALE_W-1:0] r_prescale;
    logic [3:0]            r_bit_cnt;
    logic                  r_par_en;
    logic [PRESCALE_W-1:0] w_chk;
    logic [PRESCALE_W-1:0] w_last;
    logic                  w_at_chk;
    logic                  w_at_last;
    logic                  w_at_stop_end;
    logic                  w_hold;

    // Sampler majority is valid two cycles past mid-bit.
    assign w_chk         = (r_prescale >> 1) + c_TWO;
    assign w_last        = r_prescale - c_ONE;
    assign w_at_chk      = (r_edge_cnt == w_chk);
    assign w_at_last     = (r_edge_cnt == w_last);
    assign w_at_stop_end = (r_edge_cnt == (w_chk + c_ONE));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next           = r_state;
        bus.data_samp_en = (r_state != S_IDLE);
        bus.strt_chk_en  = 1'b0;
        bus.deser_en     = 1'b0;
        bus.par_chk_en   = 1'b0;
        bus.stp_chk_en   = 1'b0;
        bus.done_chk     = 1'b0;
        bus.data_valid   = 1'b0;
        bus.frame_err    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!bus.RX_IN) w_next = S_START;
            end
            S_START: begin
                bus.strt_chk_en = w_at_chk;
                if (w_at_last) w_next = bus.strt_glitch ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                bus.deser_en = w_at_chk;
                if (w_at_last && (r_bit_cnt == c_LAST_DATA_BIT)) begin
                    w_next = r_par_en ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                bus.par_chk_en = w_at_chk;
                if (w_at_last) w_next = S_STOP;
            end
            S_STOP: begin
                bus.stp_chk_en = w_at_chk;
                // Leave before the stop bit ends so a following start edge is not missed.
                if (w_at_stop_end) w_next = S_DONE;
            end
            S_DONE: begin
                bus.done_chk   = 1'b1;
                bus.frame_err  = bus.par_err | bus.stp_err;
                bus.data_valid = ~(bus.par_err | bus.stp_err);
                w_next         = bus.RX_IN ? S_IDLE : S_START;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign w_hold = (r_state == S_IDLE) || (r_state == S_DONE) ||
                    (w_next == S_IDLE)  || (w_next == S_DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
        end else if (w_hold) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
        end else if (w_at_last) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= r_bit_cnt + 4'd1;
        end else begin
            r_edge_cnt <= r_edge_cnt + c_ONE;
        end
    end

    // Frame configuration is frozen for the whole frame once it leaves IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prescale <= '0;
            r_par_en   <= 1'b0;
        end else if (r_state == S_IDLE) begin
            r_prescale <= bus.Prescale;
            r_par_en   <= bus.PAR_EN;
        end
    end

    assign bus.edge_cnt = r_edge_cnt;
    assign bus.bit_cnt  = r_bit_cnt;
endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// Module : tb_uart_rx_fsm
// Brief  : Frame-level bench with checker/deserializer models and a result queue
// Rev    : 1.0
// ----------------------------------------------------------------------------
module tb_uart_rx_fsm;
    localparam int PRESCALE_W = 6;
    localparam int DATA_W     = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_rx_fsm_if #(.PRESCALE_W(PRESCALE_W)) bus ();

    uart_rx_fsm #(
        .PRESCALE_W (PRESCALE_W),
        .DATA_W     (DATA_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [7:0] data;
        logic       err;
        int         due;
    } exp_t;

    exp_t       sb_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         n_deser  = 0, n_strt = 0, n_par = 0, n_stp = 0;
    int         n_done   = 0, n_dv   = 0, n_fe  = 0, n_multi = 0;
    int         s_deser, s_strt, s_par, s_stp, s_done, s_dv, s_fe;
    logic [7:0] sh = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] outs_all();
        return 32'({bus.edge_cnt, bus.bit_cnt, bus.data_samp_en, bus.deser_en,
                    bus.strt_chk_en, bus.par_chk_en, bus.stp_chk_en, bus.done_chk,
                    bus.data_valid, bus.frame_err});
    endfunction

    // Sampler, deserializer and checker models plus scoreboard consumer.
    always @(negedge clk) begin
        if (!rst) begin
            bus.strt_glitch <= 1'b0;
            bus.par_err     <= 1'b0;
            bus.stp_err     <= 1'b0;
        end else begin
            if (($countones({bus.deser_en, bus.strt_chk_en, bus.par_chk_en,
                             bus.stp_chk_en, bus.done_chk}) > 1) ||
                (!bus.data_samp_en && (bus.deser_en | bus.strt_chk_en | bus.par_chk_en |
                                       bus.stp_chk_en | bus.done_chk)) ||
                ((bus.data_valid | bus.frame_err) && !bus.done_chk))
                n_multi <= n_multi + 1;
            if (bus.deser_en) begin
                n_deser <= n_deser + 1;
                sh      <= {bus.RX_IN, sh[7:1]};
            end
            if (bus.strt_chk_en) begin
                n_strt          <= n_strt + 1;
                bus.strt_glitch <= bus.RX_IN;
            end
            if (bus.par_chk_en) begin
                n_par       <= n_par + 1;
                bus.par_err <= (bus.RX_IN != (^sh));
            end
            if (bus.stp_chk_en) begin
                n_stp       <= n_stp + 1;
                bus.stp_err <= !bus.RX_IN;
            end
            if (bus.done_chk) begin
                n_done <= n_done + 1;
                if (bus.data_valid) n_dv <= n_dv + 1;
                if (bus.frame_err)  n_fe <= n_fe + 1;
                check_eq("sb_pending", 32'(sb_q.size() > 0), 32'd1);
                if (sb_q.size() > 0) begin
                    check_eq("dv_fe", 32'({bus.data_valid, bus.frame_err}),
                             32'({!sb_q[0].err, sb_q[0].err}));
                    if (!sb_q[0].err) check_eq("byte", 32'(sh), 32'(sb_q[0].data));
                    check_eq("latency", cyc, sb_q[0].due);
                    sb_q.delete(0);
                end
                bus.par_err <= 1'b0;
                bus.stp_err <= 1'b0;
            end
        end
    end

    task automatic snap();
        s_deser = n_deser; s_strt = n_strt; s_par = n_par; s_stp = n_stp;
        s_done  = n_done;  s_dv   = n_dv;   s_fe  = n_fe;
    endtask

    task automatic drive_bit(input logic v, input int p);
        bus.RX_IN = v;
        repeat (p) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int p, input logic pe, input logic [7:0] d, input logic flip);
        bus.Prescale = PRESCALE_W'(p);
        bus.PAR_EN   = pe;
        sb_q.push_back('{data: d, err: flip, due: cyc + (9 + int'(pe)) * p + p / 2 + 5});
        drive_bit(1'b0, p);
        // Mid-frame configuration changes must have no effect.
        bus.Prescale = PRESCALE_W'(p + 4);
        bus.PAR_EN   = !pe;
        for (int i = 0; i < DATA_W; i++) drive_bit(d[i], p);
        if (pe) drive_bit((^d) ^ flip, p);
        drive_bit(1'b1, p);
        bus.Prescale = PRESCALE_W'(p);
        bus.PAR_EN   = pe;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("drain", sb_q.size(), 0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic at_cycle(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: got t=%0t, expected end before 500000", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        int c;
        logic [7:0] d6;
        bus.RX_IN    = 1'b1;
        bus.Prescale = PRESCALE_W'(8);
        bus.PAR_EN   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outs", outs_all(), 32'd0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("idle_outs", outs_all(), 32'd0);

        // T1: 0x55, no parity
        snap();
        send_frame(8, 1'b0, 8'h55, 1'b0);
        drain(40);
        check_eq("t1_deser", n_deser - s_deser, 8);
        check_eq("t1_dv", n_dv - s_dv, 1);
        check_eq("t1_fe", n_fe - s_fe, 0);
        check_eq("t1_par", n_par - s_par, 0);
        check_eq("t1_stp", n_stp - s_stp, 1);

        // T2: 0xA5 with good parity
        snap();
        send_frame(8, 1'b1, 8'hA5, 1'b0);
        drain(40);
        check_eq("t2_par", n_par - s_par, 1);
        check_eq("t2_dv", n_dv - s_dv, 1);
        check_eq("t2_fe", n_fe - s_fe, 0);

        // T3: parity bit inverted
        snap();
        send_frame(8, 1'b1, 8'hA5, 1'b1);
        drain(40);
        check_eq("t3_fe", n_fe - s_fe, 1);
        check_eq("t3_dv", n_dv - s_dv, 0);
        check_eq("t3_done", n_done - s_done, 1);

        // T4: 3-cycle low pulse at Prescale 16
        snap();
        bus.Prescale = PRESCALE_W'(16);
        c = cyc;
        bus.RX_IN = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.RX_IN = 1'b1;
        at_cycle(c + 16);
        check_eq("t4_edge15", 32'(bus.edge_cnt), 32'd15);
        check_eq("t4_busy", 32'(bus.data_samp_en), 32'd1);
        at_cycle(c + 17);
        check_eq("t4_idle", 32'({bus.data_samp_en, bus.edge_cnt}), 32'd0);
        @(posedge clk);
        #1;
        repeat (4) @(posedge clk);
        #1;
        check_eq("t4_strt", n_strt - s_strt, 1);
        check_eq("t4_deser", n_deser - s_deser, 0);
        check_eq("t4_done", n_done - s_done, 0);

        // T5: back-to-back frames at Prescale 16
        snap();
        send_frame(16, 1'b0, 8'h3C, 1'b0);
        send_frame(16, 1'b0, 8'hC3, 1'b0);
        drain(60);
        check_eq("t5_dv", n_dv - s_dv, 2);
        check_eq("t5_deser", n_deser - s_deser, 16);

        // T6: asynchronous reset during data bit 4, then a clean 0x81
        snap();
        d6 = 8'h81;
        bus.Prescale = PRESCALE_W'(8);
        bus.PAR_EN   = 1'b0;
        drive_bit(1'b0, 8);
        for (int i = 0; i < 3; i++) drive_bit(d6[i], 8);
        drive_bit(d6[3], 4);
        check_eq("t6_bit", 32'(bus.bit_cnt), 32'd4);
        check_eq("t6_edge", 32'(bus.edge_cnt), 32'd3);
        #1;
        rst = 1'b0;
        #1;
        check_eq("t6_async", outs_all(), 32'd0);
        bus.RX_IN = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("t6_abort_done", n_done - s_done, 0);
        check_eq("t6_abort_deser", n_deser - s_deser, 3);
        send_frame(8, 1'b0, d6, 1'b0);
        drain(40);
        check_eq("t6_dv", n_dv - s_dv, 1);

        check_eq("strobe_excl", n_multi, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
